// File: rtl/fft_consts_pkg.sv
// Shared FFT constants and helpers: complex word width, default frame size,
// bank-state encodings and the bit-reversal address helper.
package fft_consts;

  localparam int DW_COMPLEX = 32;
  localparam int N          = 64;

  localparam logic [0:0] BANK_EMPTY = 1'b0;
  localparam logic [0:0] BANK_FULL  = 1'b1;

  // Reverses the low aw bits of addr; bits at aw and above come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int aw);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < aw) r[i] = addr[aw-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_ram_bank.sv
// Simple dual-port RAM bank: one write port and one registered read port.
// The read register holds its value when no read is enabled.
module fft_ram_bank
  import fft_consts::*;
#(
  parameter int DW    = DW_COMPLEX,
  parameter int DEPTH = N,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/fft_pingpong_ram.sv
// Ping-pong frame memory: a writer fills one bank while a reader drains the
// other; wr_last / rd_last hand a bank across. Reads may use bit-reversed order.
module fft_pingpong_ram
  import fft_consts::*;
#(
  parameter int DW    = DW_COMPLEX,
  parameter int DEPTH = N,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic          wr_ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_bitrev,
  input  logic          rd_last,
  output logic          frame_avail,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          wr_bank,
  output logic          rd_bank,
  output logic          overflow,
  output logic          underflow
);

  // Handshake: a write is taken when wr_en && wr_ready, a read when
  // rd_en && frame_avail; a strobe without its qualifier is dropped and flagged.
  logic [1:0]    full;
  logic          wr_sel;
  logic          rd_sel;
  logic          q_sel;
  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] ea;
  logic [DW-1:0] q [2];

  assign wr_ready    = (full[wr_sel] == BANK_EMPTY);
  assign frame_avail = (full[rd_sel] == BANK_FULL);
  assign wr_bank     = wr_sel;
  assign rd_bank     = rd_sel;
  assign wr_acc      = wr_en && wr_ready;
  assign rd_acc      = rd_en && frame_avail;
  assign ea          = rd_bitrev ? AW'(bitrev(32'(rd_addr), AW)) : rd_addr;
  assign rd_data     = q[q_sel];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_ram_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc && (wr_sel == 1'(b))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (rd_acc && (rd_sel == 1'(b))),
      .raddr (ea),
      .q     (q[b])
    );
  end

  // Per-bank EMPTY/FULL state; writer and reader never own the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= {BANK_EMPTY, BANK_EMPTY};
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_acc && wr_last && (wr_sel == 1'(b)))      full[b] <= BANK_FULL;
        else if (rd_acc && rd_last && (rd_sel == 1'(b))) full[b] <= BANK_EMPTY;
      end
      if (wr_acc && wr_last) wr_sel <= ~wr_sel;
      if (rd_acc && rd_last) rd_sel <= ~rd_sel;
    end
  end

  // q_sel follows the bank of the last accepted read so rd_data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sel     <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc)                 q_sel     <= rd_sel;
      if (wr_en && !wr_ready)     overflow  <= 1'b1;
      if (rd_en && !frame_avail)  underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench for fft_pingpong_ram with DEPTH = 8 and hand-computed data.
module tb_fft_pingpong_ram;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          wr_ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_bitrev = 1'b0;
  logic          rd_last = 1'b0;
  logic          frame_avail;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_bank;
  logic          rd_bank;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;
  logic [DW-1:0] bitrev_exp [8];

  fft_pingpong_ram #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_bitrev(rd_bitrev), .rd_last(rd_last),
    .frame_avail(frame_avail), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .overflow(overflow), .underflow(underflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic fill_frame(input logic [DW-1:0] base);
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = base + DW'(a); wr_last = (a == DEPTH-1);
      tick();
    end
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  // Reads one frame, checking each word against the head of exp_q.
  task automatic read_frame(input logic bitrev_mode, input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a); rd_bitrev = bitrev_mode; rd_last = (a == DEPTH-1);
      tick();
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, "_valid"}, DW'(rd_valid), 1);
      check({tag, "_data"}, rd_data, exp_d);
    end
    rd_en = 1'b0; rd_last = 1'b0; rd_bitrev = 1'b0;
  endtask

  initial begin
    bitrev_exp = '{32'h10, 32'h14, 32'h12, 32'h16, 32'h11, 32'h15, 32'h13, 32'h17};

    // reset state
    do_reset();
    check("rst_wr_ready", DW'(wr_ready), 1);
    check("rst_frame_avail", DW'(frame_avail), 0);
    check("rst_rd_valid", DW'(rd_valid), 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_flags", DW'({overflow, underflow}), 0);
    check("rst_banks", DW'({wr_bank, rd_bank}), 0);

    // natural-order frame through bank 0
    for (int a = 0; a < DEPTH-1; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h10 + DW'(a); wr_last = 1'b0;
      tick();
    end
    check("pre_last_avail", DW'(frame_avail), 0);
    wr_addr = 3'd7; wr_data = 32'h17; wr_last = 1'b1;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
    check("post_last_avail", DW'(frame_avail), 1);
    check("post_last_wr_bank", DW'(wr_bank), 1);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(32'h10 + DW'(a));
    read_frame(1'b0, "nat");
    check("nat_done_avail", DW'(frame_avail), 0);
    check("nat_done_rd_bank", DW'(rd_bank), 1);
    tick();
    check("rd_valid_idle", DW'(rd_valid), 0);
    check("rd_data_hold", rd_data, 32'h17);

    // bit-reversed read of a frame in bank 1
    fill_frame(32'h10);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(bitrev_exp[a]);
    read_frame(1'b1, "brev");
    check("brev_banks", DW'({wr_bank, rd_bank}), 0);

    // streaming: A into bank 0, then B into bank 1 while A drains
    fill_frame(32'h30);
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h40 + DW'(a); wr_last = (a == DEPTH-1);
      rd_en = 1'b1; rd_addr = AW'(a); rd_last = (a == DEPTH-1);
      check("stream_wr_ready", DW'(wr_ready), 1);
      tick();
      check("stream_valid", DW'(rd_valid), 1);
      check("stream_data", rd_data, 32'h30 + DW'(a));
    end
    wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_last = 1'b0;
    check("stream_banks", DW'({wr_bank, rd_bank}), 32'h1);
    check("stream_b_avail", DW'(frame_avail), 1);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(32'h40 + DW'(a));
    read_frame(1'b0, "stream_b");

    // overflow: both banks full, then a third write
    fill_frame(32'h50);
    fill_frame(32'h60);
    check("both_full_ready", DW'(wr_ready), 0);
    check("pre_ovf", DW'(overflow), 0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hdead; wr_last = 1'b1;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
    check("ovf_set", DW'(overflow), 1);
    check("ovf_wr_bank", DW'(wr_bank), 0);
    tick();
    tick();
    check("ovf_sticky", DW'(overflow), 1);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(32'h50 + DW'(a));
    read_frame(1'b0, "ovf_mem");
    check("ovf_still_sticky", DW'(overflow), 1);

    // underflow: read empty banks after reset
    do_reset();
    check("ovf_cleared", DW'(overflow), 0);
    rd_en = 1'b1; rd_addr = 3'd0;
    tick();
    rd_en = 1'b0;
    check("unf_set", DW'(underflow), 1);
    check("unf_rd_valid", DW'(rd_valid), 0);
    check("unf_rd_data", rd_data, 0);
    tick();
    check("unf_sticky", DW'(underflow), 1);

    // asynchronous reset mid-fill of bank 1 at addr 4
    fill_frame(32'h70);
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 32'h80 + DW'(a); wr_last = 1'b0;
      tick();
    end
    wr_addr = 3'd4; wr_data = 32'h84;
    check("pre_rst_wr_bank", DW'(wr_bank), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_wr_bank", DW'(wr_bank), 0);
    check("async_frame_avail", DW'(frame_avail), 0);
    check("async_wr_ready", DW'(wr_ready), 1);
    check("async_flags", DW'({overflow, underflow}), 0);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check("partial_discarded", DW'(frame_avail), 0);
    check("post_rst_banks", DW'({wr_bank, rd_bank}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_pingpong_ram.md
# fft_pingpong_ram

Double-buffered (ping-pong) complex-sample frame memory for the FFT datapath, built as the parametrised successor to the single-bank dual-port RAM. The block holds two banks of `DEPTH` complex words. A producer fills one bank while a consumer reads the other, and bank ownership swaps through frame-level handshakes. The read port can address in natural or bit-reversed order, selectable at run time. The block sits between the sample-ingest stage and the butterfly engine, and between FFT stages where reordering is needed.

## Interface
Parameters:
- `DW`, default `DW_COMPLEX`: complex word width (packed re/im).
- `DEPTH`, default `N`: words per bank; must be a power of two ≥ 2.
- `AW`, default `$clog2(DEPTH)`: address width; derived, do not override.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  write address within the current write bank.
- `wr_data`  in  DW  write data.
- `wr_last`  in  1  qualifies `wr_en`; marks the final write of a frame.
- `wr_ready`  out  1  the current write bank is free.
- `rd_en`  in  1  read strobe.
- `rd_addr`  in  AW  read address (natural order).
- `rd_bitrev`  in  1  when 1, the bank is read at `bitrev(rd_addr)`.
- `rd_last`  in  1  qualifies `rd_en`; marks the final read of a frame.
- `frame_avail`  out  1  the current read bank holds a complete frame.
- `rd_data`  out  DW  registered read data.
- `rd_valid`  out  1  `rd_data` is valid this cycle.
- `wr_bank`, `rd_bank`  out  1 each  current bank selects, for debug.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- State: `full[1:0]`, `wr_sel`, `rd_sel`. The block has one bank-state machine per bank with states EMPTY→FULL→EMPTY.
- Reset values:
  - `full` = 00 and `wr_sel` = `rd_sel` = 0.
  - `rd_data` = 0; `rd_valid`, `overflow` and `underflow` = 0.
  - Memory contents are not reset.
- Combinational outputs:
  - `wr_ready` = !`full[wr_sel]`.
  - `frame_avail` = `full[rd_sel]`.
  - `wr_bank` = `wr_sel`; `rd_bank` = `rd_sel`.
- Accepted write: `wr_en` & `wr_ready`. It writes `bank[wr_sel][wr_addr]`. If `wr_last` is also set, then `full[wr_sel]` ← 1 and `wr_sel` toggles.
- Accepted read: `rd_en` & `frame_avail`. It reads `bank[rd_sel][ea]`, where `ea` = `rd_bitrev` ? `bitrev(rd_addr)` : `rd_addr`. If `rd_last` is also set, then `full[rd_sel]` ← 0 and `rd_sel` toggles.
- Rejected write (`wr_en` & !`wr_ready`): no memory change and `overflow` ← 1. Rejected read (`rd_en` & !`frame_avail`): no read, `rd_valid` = 0 next cycle, and `underflow` ← 1. Both flags stay set until reset.
- Simultaneous wr_last and rd_last in one cycle: both updates apply. They always target different banks, because a writer only writes an EMPTY bank and a reader only reads a FULL one.
- Write addresses inside a frame may arrive in any order, with gaps. Only `wr_last` ends the frame.
- Reset asserted mid-frame: all flags and selects return to their reset values immediately. A partial frame is discarded.

## Timing
- Read latency is 1 cycle. An accepted read at edge k gives `rd_valid` = 1 and `rd_data` during cycle k+1.
- `rd_data` holds its last value when no read is accepted.
- Fill-to-read: `wr_last` accepted at edge k sets `full` at edge k; `frame_avail` = 1 from cycle k+1. The first read can therefore issue at edge k+1, with data in cycle k+2.
- Read-to-refill: `rd_last` accepted at edge k makes `wr_ready` of that bank visible in cycle k+1.
- Steady state: one write and one read per cycle. There is no bubble at a frame swap if both banks alternate.

## Structure
- `fft_consts` package:
  - already holds `DW_COMPLEX` and `N`;
  - add a `bitrev(addr, aw)` function for reuse by the butterfly address generator.
- One sub-module, `fft_ram_bank`: simple dual-port RAM with 1 write port, 1 registered read port, and `DW`/`DEPTH` parameters. It is instantiated twice. The top holds the state, muxes and flags.

## Test plan
All scenarios use `DEPTH` = 8.
- Reset, then idle → `wr_ready` = 1, `frame_avail` = 0, `rd_valid` = 0, `rd_data` = 0, and all flags 0.
- Write 0..7 with data = addr+0x10, with `wr_last` on addr 7; then read natural order 0..7 → `frame_avail` goes high the cycle after `wr_last`; `rd_data` = 0x10..0x17, one cycle after each read.
- Same fill, read with `rd_bitrev` = 1 over addr 0..7 → `rd_data` = 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
- Continuous streaming: frame A fills bank 0 while nothing is read; then frame B writes bank 1 while frame A is read from bank 0 → no stall, no data mixing, and `wr_bank`/`rd_bank` alternate.
- Fill both banks with no reads, then attempt a 3rd write → `wr_ready` = 0, memory unchanged, and `overflow` = 1 and sticky. A read on empty banks after reset → `underflow` = 1 and `rd_valid` = 0.
- Assert `rst_n` low mid-fill at addr 4 → `full` = 00, `wr_bank` = 0, and `overflow`/`underflow` cleared immediately, before any clock edge.
